mux_rr_arbiter: RTL



---
 rtl/mux_arb_pkg.sv | 17 +
 rtl/rr_pick4.sv | 27 ++
 rtl/mux_rr_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin winner search over four requests, starting after ptr.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // 2-bit addition wraps 3 -> 0; k = 4 lands back on ptr itself (lowest priority).
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the Mux_4_1 select, with hold cap and a one-cycle gap between grants.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             preempt
);

  localparam int unsigned HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             preempt_q, preempt_d;

  logic             win_any;
  logic [SEL_W-1:0] win_idx;
  logic             others_waiting;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (win_any),
    .idx (win_idx)
  );

  assign others_waiting = |(req & ~onehot(ptr_q));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;

    unique case (state_q)
      IDLE, GAP: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
        if (en && win_any) begin
          state_d = GRANT;
          gnt_d   = onehot(win_idx);
          sel_d   = win_idx;
          valid_d = 1'b1;
          ptr_d   = win_idx;
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        // A release takes precedence over expiry, so a simultaneous drop never flags preempt.
        if (!req[ptr_q] || !en) begin
          state_d = GAP;
          gnt_d   = '0;
          valid_d = 1'b0;
        end else if (hold_q == HOLD_MAX && others_waiting) begin
          state_d   = GAP;
          gnt_d     = '0;
          valid_d   = 1'b0;
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= SEL_W'(N_REQ - 1);
      hold_q    <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign valid   = valid_q;
  assign preempt = preempt_q;

endmodule
